// File: rtl/pipelined_three_operand_adder.sv
// rtl/pipelined_three_operand_adder.sv - three-stage a+b+cin(+/-)c adder with valid/ready; optional result counter under THREE_OPERAND_ADDER_COUNT_EN
module pipelined_three_operand_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             cin,
  input  logic             sub_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] sum,
  output logic             carry
`ifdef THREE_OPERAND_ADDER_COUNT_EN
  ,
  input  logic             count_clr,
  output logic [31:0]      result_count
`endif
);

  localparam int W2     = WIDTH + 2;
  localparam int LEVELS = $clog2(W2);

  // Kogge-Stone group generate; bit i of the result is the carry out of bit i.
  function automatic logic [W2-1:0] prefix_carry(input logic [W2-1:0] g_in,
                                                 input logic [W2-1:0] p_in);
    logic [W2-1:0] g, p, gn, pn;
    g = g_in;
    p = p_in;
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      gn = g;
      pn = p;
      for (int i = 0; i < W2; i++) begin
        if (i >= (1 << lvl)) begin
          gn[i] = g[i] | (p[i] & g[i - (1 << lvl)]);
          pn[i] = p[i] & p[i - (1 << lvl)];
        end
      end
      g = gn;
      p = pn;
    end
    return g;
  endfunction

  logic          adv;
  logic          v1, v2, v3;
  logic [W2-1:0] s1_s, s1_cr;
  logic          s1_ci;
  logic [W2-1:0] s2_p, s2_g;
  logic          s2_ci;
  logic [W2-1:0] sum_q;

  logic [W2-1:0] ax, bx, cx, maj, s_d, cr_d;
  logic [W2-1:0] g_d, p_d, gseed, carries_d;

  assign adv       = !v3 || out_ready;
  assign in_ready  = adv;
  assign out_valid = v3;
  assign sum       = sum_q;
  assign carry     = sum_q[W2-1];

  // S1: c is inverted after zero-extension; cin fills the free cr[0] slot,
  // and the subtract +1 rides along as the prefix carry-in.
  always_comb begin
    ax   = {2'b00, a};
    bx   = {2'b00, b};
    cx   = sub_c ? ~{2'b00, c} : {2'b00, c};
    s_d  = ax ^ bx ^ cx;
    maj  = (ax & bx) | (ax & cx) | (bx & cx);
    cr_d = {maj[W2-2:0], cin};
  end

  always_comb begin
    g_d       = s1_s & s1_cr;
    p_d       = s1_s ^ s1_cr;
    gseed     = g_d;
    gseed[0]  = g_d[0] | (p_d[0] & s1_ci);
    carries_d = prefix_carry(gseed, p_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      s1_s  <= '0;
      s1_cr <= '0;
      s1_ci <= 1'b0;
      s2_p  <= '0;
      s2_g  <= '0;
      s2_ci <= 1'b0;
      sum_q <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      if (in_valid) begin
        s1_s  <= s_d;
        s1_cr <= cr_d;
        s1_ci <= sub_c;
      end
      if (v1) begin
        s2_p  <= p_d;
        s2_g  <= carries_d;
        s2_ci <= s1_ci;
      end
      if (v2) begin
        sum_q <= s2_p ^ {s2_g[W2-2:0], s2_ci};
      end
    end
  end

`ifdef THREE_OPERAND_ADDER_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_count <= '0;
    end else if (count_clr) begin
      result_count <= '0;
    end else if (v3 && out_ready) begin
      result_count <= result_count + 32'd1;
    end
  end
`endif

endmodule
